// File: rtl/comet_ii_loader_pkg.sv
// Shared types and constants for the COMET II boot loader.
package comet_ii_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int HDR_BYTES = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_START,
        S_RUN,
        S_ERR
    } state_t;

    // States in which the byte stream is being consumed.
    function automatic logic takes_bytes(state_t s);
        return (s == S_IDLE) || (s == S_HDR) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/comet_ii_loader_if.sv
// Byte-stream input and memory write port of the loader.
interface comet_ii_loader_if;
    import comet_ii_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Host / memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/comet_ii_loader_rx.sv
// Byte-to-word assembler: high-byte latch, running XOR and inter-byte idle timer.
module comet_ii_loader_rx
    import comet_ii_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    input  logic              i_in_frame,
    input  logic              i_in_data,
    input  logic              i_in_csum,
    output logic              o_word_valid,
    output logic [DATA_W-1:0] o_word,
    output logic              o_csum_ok,
    output logic              o_timeout
);

    logic [7:0]  r_hi;
    logic        r_phase;
    logic [7:0]  r_xor;
    logic [15:0] r_idle;

    always_ff @(posedge mclk) begin
        if (rst || i_clear) begin
            r_hi    <= 8'h00;
            r_phase <= 1'b0;
            r_xor   <= 8'h00;
            r_idle  <= 16'h0000;
        end else begin
            // The checksum byte itself is not part of the running XOR.
            if (i_accept && !i_in_csum)
                r_xor <= r_xor ^ i_byte;
            if (i_accept && i_in_data) begin
                r_phase <= ~r_phase;
                if (!r_phase)
                    r_hi <= i_byte;
            end
            if (!i_in_frame || i_accept)
                r_idle <= 16'h0000;
            else if (r_idle != TIMEOUT)
                r_idle <= r_idle + 16'd1;
        end
    end

    assign o_word_valid = i_accept && i_in_data && r_phase;
    assign o_word       = {r_hi, i_byte};
    assign o_csum_ok    = (i_byte == r_xor);
    // Fires on the idle cycle that brings the count up to TIMEOUT.
    assign o_timeout    = i_in_frame && !i_accept && ((r_idle + 16'd1) == TIMEOUT);

endmodule

// File: rtl/comet_ii_loader.sv
// COMET II boot loader: parses a framed byte image into memory, then releases the core.
module comet_ii_loader
    import comet_ii_pkg::*;
#(
    parameter logic [15:0] TIMEOUT    = 16'hFFFF,
    parameter logic [15:0] DEFAULT_SP = 16'h0000
) (
    input  logic              mclk,
    input  logic              rst,
    comet_ii_loader_if.slave  bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              cpu_init,
    output logic [ADDR_W-1:0] cpu_pr_init,
    output logic [ADDR_W-1:0] cpu_sp_init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    logic [2:0]        r_hdr_cnt;
    logic [55:0]       r_hdr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_words;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_accept;
    logic              w_in_frame;
    logic [63:0]       w_hdr_next;
    logic              w_word_valid;
    logic [DATA_W-1:0] w_word;
    logic              w_csum_ok;
    logic              w_timeout;

    assign bus.in_ready  = takes_bytes(r_state) && !rst;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_in_frame = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_hdr_next = {r_hdr, bus.in_data};

    comet_ii_loader_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .mclk         (mclk),
        .rst          (rst),
        .i_clear      (reload),
        .i_accept     (w_accept),
        .i_byte       (bus.in_data),
        .i_in_frame   (w_in_frame),
        .i_in_data    (r_state == S_DATA),
        .i_in_csum    (r_state == S_CSUM),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_csum_ok    (w_csum_ok),
        .o_timeout    (w_timeout)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr_cnt   <= 3'd0;
            r_hdr       <= '0;
            r_addr      <= '0;
            r_words     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            cpu_rst     <= 1'b1;
            cpu_init    <= 1'b0;
            cpu_pr_init <= '0;
            cpu_sp_init <= DEFAULT_SP;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else if (reload) begin
            // Any byte or write landing in this cycle is dropped.
            r_state   <= S_IDLE;
            r_hdr_cnt <= 3'd0;
            r_words   <= '0;
            r_mem_we  <= 1'b0;
            cpu_rst   <= 1'b1;
            cpu_init  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            cpu_init <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hdr     <= w_hdr_next[55:0];
                        r_hdr_cnt <= 3'd1;
                        busy      <= 1'b1;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_timeout) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERR;
                    end else if (w_accept) begin
                        r_hdr <= w_hdr_next[55:0];
                        if (r_hdr_cnt == 3'(HDR_BYTES - 1)) begin
                            r_addr  <= w_hdr_next[63:48];
                            r_words <= w_hdr_next[47:32];
                            r_state <= (w_hdr_next[47:32] != 16'h0000) ? S_DATA : S_CSUM;
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_timeout) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERR;
                    end else if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_waddr <= r_addr;
                        r_mem_wdata <= w_word;
                        r_addr      <= r_addr + 16'd1;
                        r_words     <= r_words - 16'd1;
                        if (r_words == 16'd1)
                            r_state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (w_timeout) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_ERR;
                    end else if (w_accept) begin
                        busy <= 1'b0;
                        if (w_csum_ok) begin
                            // Outputs go live together with the START cycle.
                            cpu_init    <= 1'b1;
                            cpu_rst     <= 1'b0;
                            done        <= 1'b1;
                            cpu_pr_init <= r_hdr[31:16];
                            cpu_sp_init <= r_hdr[15:0];
                            r_state     <= S_START;
                        end else begin
                            err     <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_START: r_state <= S_RUN;
                S_RUN:   r_state <= S_RUN;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comet_ii_loader.sv
// Randomized and directed frames against a byte-level model of the load protocol.
module tb_comet_ii_loader;
    import comet_ii_pkg::*;

    localparam logic [15:0] TMO = 16'd16;
    localparam logic [15:0] DSP = 16'hBEEF;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic        cpu_rst, cpu_init, busy, done, err;
    logic [15:0] cpu_pr_init, cpu_sp_init;

    comet_ii_loader_if bus();

    comet_ii_loader #(.TIMEOUT(TMO), .DEFAULT_SP(DSP)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .bus         (bus),
        .reload      (reload),
        .cpu_rst     (cpu_rst),
        .cpu_init    (cpu_init),
        .cpu_pr_init (cpu_pr_init),
        .cpu_sp_init (cpu_sp_init),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 mclk = ~mclk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_init = 0;
    logic [31:0] got_q[$];
    logic [15:0] wq[$];
    logic [15:0] cur_pr = 16'h0000;
    logic [15:0] cur_sp = DSP;

    // Write and init-pulse monitor, sampled mid-cycle.
    always @(negedge mclk) begin
        if (bus.mem_we) got_q.push_back({bus.mem_waddr, bus.mem_wdata});
        if (cpu_init) n_init++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge mclk);
            n++;
        end
        if (n >= 50) chk("ready_wait", 32'd0, 32'd1);
        @(negedge mclk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge mclk);
        reload = 1'b0;
    endtask

    // Sends a frame built from wq and checks writes and final status against the rules.
    task automatic run_frame(input logic [15:0] sa, input logic [15:0] pr,
                             input logic [15:0] sp, input bit bad);
        logic [7:0]  bq[$];
        logic [7:0]  x;
        logic [15:0] n;
        logic [15:0] a;
        n = 16'(wq.size());
        bq = {sa[15:8], sa[7:0], n[15:8], n[7:0], pr[15:8], pr[7:0], sp[15:8], sp[7:0]};
        foreach (wq[i]) begin
            bq.push_back(wq[i][15:8]);
            bq.push_back(wq[i][7:0]);
        end
        x = 8'h00;
        foreach (bq[i]) x = x ^ bq[i];
        if (bad) x = x ^ (8'h01 << $urandom_range(0, 7));
        got_q.delete();
        n_init = 0;
        foreach (bq[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge mclk);
            send_byte(bq[i]);
        end
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        send_byte(x);
        repeat (4) @(negedge mclk);
        chk("wr_count", got_q.size(), wq.size());
        foreach (wq[i]) begin
            a = sa + 16'(i);
            if (i < got_q.size()) chk("wr_word", got_q[i], {a, wq[i]});
        end
        if (!bad) begin
            cur_pr = pr;
            cur_sp = sp;
        end
        chk("done", {31'd0, done}, {31'd0, !bad});
        chk("err", {31'd0, err}, {31'd0, bad});
        chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, bad});
        chk("init_pulses", n_init, bad ? 0 : 1);
        chk("pr_init", {16'd0, cpu_pr_init}, {16'd0, cur_pr});
        chk("sp_init", {16'd0, cpu_sp_init}, {16'd0, cur_sp});
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge mclk);
        chk("rdy_in_reset", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge mclk);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_status", {25'd0, bus.mem_we, cpu_rst, cpu_init, busy, done, err, 1'b0},
            {25'd0, 7'b0100000});
        chk("rst_waddr", {bus.mem_waddr, bus.mem_wdata}, 32'd0);
        chk("rst_pr", {16'd0, cpu_pr_init}, 32'd0);
        chk("rst_sp", {16'd0, cpu_sp_init}, {16'd0, DSP});

        // Reference frame, good then corrupted checksum.
        wq = {16'h1234, 16'hABCD};
        run_frame(16'h0010, 16'h0010, 16'hFFF0, 1'b0);
        do_reload();
        chk("run_reload_rst", {31'd0, cpu_rst}, 32'd1);
        chk("run_reload_done", {31'd0, done}, 32'd0);
        chk("run_reload_rdy", {31'd0, bus.in_ready}, 32'd1);
        run_frame(16'h0010, 16'h0010, 16'hFFF0, 1'b1);

        // Address wrap, then empty image.
        do_reload();
        chk("err_cleared", {31'd0, err}, 32'd0);
        wq = {16'h0001, 16'h0002};
        run_frame(16'hFFFF, 16'h1000, 16'h2000, 1'b0);
        do_reload();
        wq = {};
        run_frame(16'h0400, 16'h0400, 16'h8000, 1'b0);

        // Stall after three header bytes.
        do_reload();
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (15) @(negedge mclk);
        chk("tmo_early", {31'd0, err}, 32'd0);
        @(negedge mclk);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        do_reload();
        wq = {16'h5A5A};
        run_frame(16'h0020, 16'h0020, 16'h7FFE, 1'b0);

        // Reload on the same edge as a low data byte.
        do_reload();
        wq = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA);
        got_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        reload = 1'b1;
        @(negedge mclk);
        reload = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        repeat (3) @(negedge mclk);
        chk("mid_no_write", got_q.size(), 32'd0);
        run_frame(16'h0300, 16'h0300, 16'h0FFE, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 5; f++) begin
            int nw;
            do_reload();
            nw = $urandom_range(1, 6);
            wq = {};
            for (int k = 0; k < nw; k++) wq.push_back(16'($urandom));
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
